ahb_slave_if: RTL and testbench

- AHB slave front-end of the AHB-to-APB bridge. It sits directly downstream of the AHB master and upstream of the APB FSM controller.
- Samples AHB address phases and decodes the target into one of three APB peripheral selects.
- Pipelines address, control and write data, then issues a one-cycle transfer request (valid) to the APB controller.
- Stretches the AHB data phase with Hreadyout until the APB side signals completion. Generates the two-cycle AHB ERROR response for unmapped addresses.

---
 rtl/ahb_slave_if_if.sv | 33 +++
 rtl/ahb_slave_if.sv | 96 +++++++++
 tb/tb_ahb_slave_if.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB master, the bridge front-end and the APB controller.
// The master modport is the view of whatever drives the AHB side and apb_done/Prdata.
interface ahb_slave_if_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        apb_done;
  logic        valid;
  logic [31:0] Haddr1;
  logic [31:0] Haddr2;
  logic [31:0] Hwdata1;
  logic [31:0] Hwdata2;
  logic        Hwritereg;
  logic [2:0]  tempselx;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  modport master (
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, apb_done,
    input  valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
           Hreadyout, Hresp, Hrdata
  );

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, Prdata, apb_done,
    output valid, Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg, tempselx,
           Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb_slave_if.sv
// AHB slave front-end of the AHB-to-APB bridge: decodes, pipelines and issues one
// valid pulse per mapped transfer, stretching the data phase until apb_done.
module ahb_slave_if #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic           Hclk,
  input  logic           Hresetn,
  ahb_slave_if_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, XFER, ERR1, ERR2} state_t;

  state_t     state;
  logic [2:0] decode;
  logic       mapped;
  logic       active_trans;
  logic       in_done;
  logic       accept;

  // Offset-from-base compare: addresses below a base wrap to a huge offset, so one
  // unsigned compare covers both window edges.
  always_comb begin
    decode[0] = (bus.Haddr - SLV0_BASE) < SLV_SIZE;
    decode[1] = (bus.Haddr - SLV1_BASE) < SLV_SIZE;
    decode[2] = (bus.Haddr - SLV2_BASE) < SLV_SIZE;
    mapped    = |decode;
  end

  // valid is high only in the first data-phase cycle, which is where apb_done is ignored.
  always_comb begin
    active_trans = (bus.Htrans == 2'b10) || (bus.Htrans == 2'b11);
    in_done      = (state == XFER) && !bus.valid && bus.apb_done;
    accept       = bus.Hreadyin && bus.Hreadyout && active_trans &&
                   ((state == IDLE) || in_done);
  end

  always_comb begin
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    case (state)
      IDLE: bus.Hreadyout = 1'b1;
      XFER: bus.Hreadyout = in_done;
      ERR1: begin
        bus.Hreadyout = 1'b0;
        bus.Hresp     = 2'b01;
      end
      ERR2: begin
        bus.Hreadyout = 1'b1;
        bus.Hresp     = 2'b01;
      end
      default: bus.Hreadyout = 1'b1;
    endcase
    bus.Hrdata = (in_done && !bus.Hwritereg) ? bus.Prdata : 32'h0;
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state         <= IDLE;
      bus.valid     <= 1'b0;
      bus.Haddr1    <= 32'h0;
      bus.Haddr2    <= 32'h0;
      bus.Hwdata1   <= 32'h0;
      bus.Hwdata2   <= 32'h0;
      bus.Hwritereg <= 1'b0;
      bus.tempselx  <= 3'b000;
    end else begin
      if (accept) begin
        bus.Haddr2    <= bus.Haddr1;
        bus.Haddr1    <= bus.Haddr;
        bus.Hwritereg <= bus.Hwrite;
        bus.tempselx  <= decode;
        bus.Hwdata2   <= bus.Hwdata1;
      end
      // Write data arrives one cycle after its address phase.
      if ((state == XFER) && bus.valid) begin
        bus.Hwdata1 <= bus.Hwdata;
      end
      bus.valid <= accept && mapped;
      if (accept) begin
        state <= mapped ? XFER : ERR1;
      end else begin
        case (state)
          IDLE:    state <= IDLE;
          XFER:    state <= in_done ? IDLE : XFER;
          ERR1:    state <= ERR2;
          ERR2:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: expected transfers are queued when the address
// phase is driven and popped when the DUT raises valid.
module tb_ahb_slave_if;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  logic   Hclk = 1'b0;
  logic   Hresetn;
  exp_t   sb[$];
  int     checks = 0;
  int     fails = 0;

  ahb_slave_if_if bus ();

  ahb_slave_if dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus)
  );

  always #5 Hclk = ~Hclk;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic settle();
    @(negedge Hclk);
  endtask

  task automatic drive_idle();
    bus.Htrans   = 2'b00;
    bus.apb_done = 1'b0;
    bus.Hreadyin = 1'b1;
  endtask

  task automatic test_reset();
    Hresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.Htrans   = 2'($urandom);
      bus.Hwrite   = 1'($urandom);
      bus.Haddr    = $urandom;
      bus.Hwdata   = $urandom;
      bus.Prdata   = $urandom;
      bus.apb_done = 1'($urandom);
      bus.Hreadyin = 1'($urandom);
      settle();
      checks++;
      if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00 || bus.valid !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_ctrl: Hreadyout=%b Hresp=%b valid=%b required 1/00/0",
                 bus.Hreadyout, bus.Hresp, bus.valid);
      end
      tick();
    end
    checks++;
    if (bus.tempselx !== 3'b000 || bus.Hwritereg !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_sel: tempselx=%b Hwritereg=%b required 000/0",
               bus.tempselx, bus.Hwritereg);
    end
    checks++;
    if ({bus.Haddr1, bus.Haddr2, bus.Hwdata1, bus.Hwdata2, bus.Hrdata} !== 160'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: Haddr1=%h Haddr2=%h Hwdata1=%h Hwdata2=%h Hrdata=%h required all 0",
               bus.Haddr1, bus.Haddr2, bus.Hwdata1, bus.Hwdata2, bus.Hrdata);
    end
    drive_idle();
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h0;
    bus.Hwdata = 32'h0;
    bus.Prdata = 32'h0;
    Hresetn    = 1'b1;
    tick();
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b1 || bus.valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_release: Hreadyout=%b valid=%b required 1/0", bus.Hreadyout, bus.valid);
    end
    tick();
  endtask

  task automatic test_single_write();
    exp_t e = exp_t'{32'h0, 1'b0, 3'b000, 32'h0};
    bus.Htrans   = 2'b10;
    bus.Hwrite   = 1'b1;
    bus.Haddr    = 32'h8000_0000;
    bus.Hreadyin = 1'b1;
    sb.push_back(exp_t'{32'h8000_0000, 1'b1, 3'b001, 32'h24});
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wr_addr_ready: Hreadyout=%b required 1", bus.Hreadyout);
    end
    tick();
    bus.Htrans = 2'b00;
    bus.Hwdata = 32'h24;
    settle();
    checks++;
    if (bus.valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL wr_valid: valid=%b queued=%0d required valid=1", bus.valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.Haddr1 !== e.addr || bus.Hwritereg !== e.wr || bus.tempselx !== e.sel) begin
        fails++;
        $display("[TB] FAIL wr_beat: Haddr1=%h Hwritereg=%b tempselx=%b required %h/%b/%b",
                 bus.Haddr1, bus.Hwritereg, bus.tempselx, e.addr, e.wr, e.sel);
      end
    end
    checks++;
    if (bus.Hreadyout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL wr_wait1: Hreadyout=%b required 0", bus.Hreadyout);
    end
    tick();
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b0 || bus.valid !== 1'b0 || bus.Hwdata1 !== e.wdata) begin
      fails++;
      $display("[TB] FAIL wr_wait2: Hreadyout=%b valid=%b Hwdata1=%h required 0/0/%h",
               bus.Hreadyout, bus.valid, bus.Hwdata1, e.wdata);
    end
    tick();
    bus.apb_done = 1'b1;
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00 || bus.Hrdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL wr_done: Hreadyout=%b Hresp=%b Hrdata=%h required 1/00/0",
               bus.Hreadyout, bus.Hresp, bus.Hrdata);
    end
    tick();
    bus.apb_done = 1'b0;
    settle();
    checks++;
    if (bus.valid !== 1'b0 || bus.Hreadyout !== 1'b1 || bus.tempselx !== 3'b001 || bus.Hwritereg !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wr_after: valid=%b Hreadyout=%b tempselx=%b Hwritereg=%b required 0/1/001/1",
               bus.valid, bus.Hreadyout, bus.tempselx, bus.Hwritereg);
    end
    tick();
  endtask

  task automatic test_single_read();
    exp_t e;
    bus.Htrans = 2'b10;
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h8400_0010;
    bus.Prdata = 32'hA5A5_0001;
    sb.push_back(exp_t'{32'h8400_0010, 1'b0, 3'b010, 32'h0});
    tick();
    bus.Htrans = 2'b00;
    bus.Hwdata = 32'h0;
    settle();
    checks++;
    if (bus.valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL rd_valid: valid=%b queued=%0d required valid=1", bus.valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.Haddr1 !== e.addr || bus.Hwritereg !== e.wr || bus.tempselx !== e.sel) begin
        fails++;
        $display("[TB] FAIL rd_beat: Haddr1=%h Hwritereg=%b tempselx=%b required %h/%b/%b",
                 bus.Haddr1, bus.Hwritereg, bus.tempselx, e.addr, e.wr, e.sel);
      end
    end
    checks++;
    if (bus.Hrdata !== 32'h0 || bus.Hreadyout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rd_first: Hrdata=%h Hreadyout=%b required 0/0", bus.Hrdata, bus.Hreadyout);
    end
    tick();
    bus.apb_done = 1'b1;
    settle();
    checks++;
    if (bus.Hrdata !== 32'hA5A5_0001 || bus.Hreadyout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL rd_done: Hrdata=%h Hreadyout=%b required a5a50001/1", bus.Hrdata, bus.Hreadyout);
    end
    tick();
    bus.apb_done = 1'b0;
    settle();
    checks++;
    if (bus.Hrdata !== 32'h0 || bus.tempselx !== 3'b010 || bus.Haddr1 !== 32'h8400_0010) begin
      fails++;
      $display("[TB] FAIL rd_hold: Hrdata=%h tempselx=%b Haddr1=%h required 0/010/84000010",
               bus.Hrdata, bus.tempselx, bus.Haddr1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   nvalid = 0;
    bus.Htrans = 2'b10;
    bus.Hwrite = 1'b1;
    bus.Haddr  = 32'h8800_0000;
    sb.push_back(exp_t'{32'h8800_0000, 1'b1, 3'b100, 32'hB000_0000});
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.Hwdata   = 32'hB000_0000 + 32'(i);
      bus.apb_done = 1'b0;
      if (i < 3) begin
        bus.Htrans = 2'b11;
        bus.Haddr  = 32'h8800_0000 + 32'(i + 1);
        sb.push_back(exp_t'{32'h8800_0000 + 32'(i + 1), 1'b1, 3'b100, 32'hB000_0000 + 32'(i + 1)});
      end else begin
        bus.Htrans = 2'b00;
      end
      settle();
      checks++;
      if (bus.valid !== 1'b1 || sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL burst_valid%0d: valid=%b queued=%0d required valid=1", i, bus.valid, sb.size());
      end else begin
        nvalid++;
        e = sb.pop_front();
        checks++;
        if (bus.Haddr1 !== e.addr || bus.Hwritereg !== e.wr || bus.tempselx !== e.sel) begin
          fails++;
          $display("[TB] FAIL burst_beat%0d: Haddr1=%h Hwritereg=%b tempselx=%b required %h/%b/%b",
                   i, bus.Haddr1, bus.Hwritereg, bus.tempselx, e.addr, e.wr, e.sel);
        end
      end
      if (i > 0) begin
        checks++;
        if (bus.Haddr2 !== 32'h8800_0000 + 32'(i - 1) || bus.Hwdata2 !== 32'hB000_0000 + 32'(i - 1)) begin
          fails++;
          $display("[TB] FAIL burst_prev%0d: Haddr2=%h Hwdata2=%h required %h/%h", i, bus.Haddr2,
                   bus.Hwdata2, 32'h8800_0000 + 32'(i - 1), 32'hB000_0000 + 32'(i - 1));
        end
      end
      tick();
      bus.apb_done = 1'b1;
      settle();
      checks++;
      if (bus.Hreadyout !== 1'b1 || bus.Hwdata1 !== 32'hB000_0000 + 32'(i)) begin
        fails++;
        $display("[TB] FAIL burst_done%0d: Hreadyout=%b Hwdata1=%h required 1/%h",
                 i, bus.Hreadyout, bus.Hwdata1, 32'hB000_0000 + 32'(i));
      end
      tick();
    end
    bus.apb_done = 1'b0;
    settle();
    checks++;
    if (bus.valid !== 1'b0 || bus.Hreadyout !== 1'b1 || nvalid != 4) begin
      fails++;
      $display("[TB] FAIL burst_end: valid=%b Hreadyout=%b pulses=%0d required 0/1/4",
               bus.valid, bus.Hreadyout, nvalid);
    end
    tick();
  endtask

  task automatic test_unmapped();
    bus.Htrans = 2'b10;
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h9000_0000;
    tick();
    bus.Htrans = 2'b00;
    settle();
    checks++;
    if (bus.valid !== 1'b0 || bus.Hreadyout !== 1'b0 || bus.Hresp !== 2'b01) begin
      fails++;
      $display("[TB] FAIL err1: valid=%b Hreadyout=%b Hresp=%b required 0/0/01",
               bus.valid, bus.Hreadyout, bus.Hresp);
    end
    tick();
    bus.Htrans = 2'b10;
    bus.Haddr  = 32'h8000_0000;
    settle();
    checks++;
    if (bus.valid !== 1'b0 || bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b01) begin
      fails++;
      $display("[TB] FAIL err2: valid=%b Hreadyout=%b Hresp=%b required 0/1/01",
               bus.valid, bus.Hreadyout, bus.Hresp);
    end
    tick();
    bus.Htrans = 2'b00;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (bus.valid !== 1'b0 || bus.Hreadyout !== 1'b1 || bus.Hresp !== 2'b00) begin
        fails++;
        $display("[TB] FAIL err_idle%0d: valid=%b Hreadyout=%b Hresp=%b required 0/1/00",
                 i, bus.valid, bus.Hreadyout, bus.Hresp);
      end
      tick();
    end
  endtask

  task automatic test_decode_bounds();
    exp_t        e;
    logic [31:0] addrs[6] = '{32'h7FFF_FFFC, 32'h8000_0000, 32'h83FF_FFFF,
                              32'h8400_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
    logic [2:0]  sels[6]  = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b100, 3'b000};
    for (int i = 0; i < 6; i++) begin
      bus.Htrans = 2'b10;
      bus.Hwrite = 1'b0;
      bus.Haddr  = addrs[i];
      if (sels[i] != 3'b000) sb.push_back(exp_t'{addrs[i], 1'b0, sels[i], 32'h0});
      tick();
      bus.Htrans = 2'b00;
      settle();
      if (sels[i] != 3'b000) begin
        checks++;
        if (bus.valid !== 1'b1 || sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL dec_valid %h: valid=%b queued=%0d required valid=1", addrs[i], bus.valid, sb.size());
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.Haddr1 !== e.addr || bus.tempselx !== e.sel) begin
            fails++;
            $display("[TB] FAIL dec_sel %h: Haddr1=%h tempselx=%b required %h/%b",
                     addrs[i], bus.Haddr1, bus.tempselx, e.addr, e.sel);
          end
        end
        tick();
        bus.apb_done = 1'b1;
        settle();
        tick();
        bus.apb_done = 1'b0;
      end else begin
        checks++;
        if (bus.valid !== 1'b0 || bus.Hresp !== 2'b01 || bus.Hreadyout !== 1'b0 || bus.tempselx !== 3'b000) begin
          fails++;
          $display("[TB] FAIL dec_unmapped %h: valid=%b Hresp=%b Hreadyout=%b tempselx=%b required 0/01/0/000",
                   addrs[i], bus.valid, bus.Hresp, bus.Hreadyout, bus.tempselx);
        end
        tick();
        tick();
      end
    end
  endtask

  task automatic test_early_done();
    exp_t e;
    bus.Htrans = 2'b10;
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h8000_0004;
    bus.Prdata = 32'hDEAD_BEEF;
    sb.push_back(exp_t'{32'h8000_0004, 1'b0, 3'b001, 32'h0});
    tick();
    bus.Htrans   = 2'b00;
    bus.apb_done = 1'b1;
    settle();
    checks++;
    if (bus.valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL early_valid: valid=%b queued=%0d required valid=1", bus.valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.Haddr1 !== e.addr || bus.tempselx !== e.sel) begin
        fails++;
        $display("[TB] FAIL early_beat: Haddr1=%h tempselx=%b required %h/%b",
                 bus.Haddr1, bus.tempselx, e.addr, e.sel);
      end
    end
    checks++;
    if (bus.Hreadyout !== 1'b0 || bus.Hrdata !== 32'h0) begin
      fails++;
      $display("[TB] FAIL early_ignored: Hreadyout=%b Hrdata=%h required 0/0", bus.Hreadyout, bus.Hrdata);
    end
    tick();
    bus.apb_done = 1'b0;
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b0 || bus.valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL early_wait: Hreadyout=%b valid=%b required 0/0", bus.Hreadyout, bus.valid);
    end
    tick();
    bus.apb_done = 1'b1;
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b1 || bus.Hrdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("[TB] FAIL early_done: Hreadyout=%b Hrdata=%h required 1/deadbeef", bus.Hreadyout, bus.Hrdata);
    end
    tick();
    bus.apb_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bus.Htrans = 2'b10;
    bus.Hwrite = 1'b1;
    bus.Haddr  = 32'h8400_0000;
    sb.push_back(exp_t'{32'h8400_0000, 1'b1, 3'b010, 32'h0});
    tick();
    bus.Htrans = 2'b00;
    bus.Hwdata = 32'h1234_5678;
    settle();
    checks++;
    if (bus.valid !== 1'b1 || sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL mid_valid: valid=%b queued=%0d required valid=1", bus.valid, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (bus.Haddr1 !== e.addr || bus.tempselx !== e.sel) begin
        fails++;
        $display("[TB] FAIL mid_beat: Haddr1=%h tempselx=%b required %h/%b",
                 bus.Haddr1, bus.tempselx, e.addr, e.sel);
      end
    end
    tick();
    settle();
    checks++;
    if (bus.Hreadyout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_wait: Hreadyout=%b required 0", bus.Hreadyout);
    end
    Hresetn = 1'b0;
    #1;
    checks++;
    if (bus.Hreadyout !== 1'b1 || bus.valid !== 1'b0 || bus.tempselx !== 3'b000 || bus.Hwdata1 !== 32'h0) begin
      fails++;
      $display("[TB] FAIL mid_reset: Hreadyout=%b valid=%b tempselx=%b Hwdata1=%h required 1/0/000/0",
               bus.Hreadyout, bus.valid, bus.tempselx, bus.Hwdata1);
    end
    bus.Htrans   = 2'b01;
    bus.apb_done = 1'b1;
    tick();
    Hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.Htrans   = (i < 2) ? 2'b01 : 2'b00;
      bus.apb_done = (i < 2);
      settle();
      checks++;
      if (bus.valid !== 1'b0 || bus.Hreadyout !== 1'b1) begin
        fails++;
        $display("[TB] FAIL mid_after%0d: valid=%b Hreadyout=%b required 0/1", i, bus.valid, bus.Hreadyout);
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    Hresetn = 1'b1;
    drive_idle();
    bus.Hwrite = 1'b0;
    bus.Haddr  = 32'h0;
    bus.Hwdata = 32'h0;
    bus.Prdata = 32'h0;
    #2;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_unmapped();
    test_decode_bounds();
    test_early_done();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d transfers never produced valid, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
